tnn_feature_packer: RTL and testbench
=====================================

TNN_FEATURE_PACKER -- requirements
Module: tnn_feature_packer

Interface
REQ-001 Parameter FEAT_W, default 8, raw feature sample width.
REQ-002 Parameter N_FEAT, fixed 5, features per frame (fields a..e of the classifier input).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  raw sample valid.
REQ-006 in_data  input  FEAT_W  raw unsigned feature sample, feature order a,b,c,d,e.
REQ-007 in_last  input  1  marks final sample of a frame.
REQ-008 in_ready  output  1  packer accepts a sample this cycle.
REQ-009 cfg_we  input  1  threshold table write strobe.
REQ-010 cfg_addr  input  4  threshold index = feature*3 + level (0..14); 15 ignored.
REQ-011 cfg_data  input  FEAT_W  threshold value.
REQ-012 out_valid  output  1  packed frame available.
REQ-013 out_vec  output  10  packed 2-bit codes; [1:0]=a, [3:2]=b, [5:4]=c, [7:6]=d, [9:8]=e.
REQ-014 out_ready  input  1  consumer (classifier side) takes the frame.
REQ-015 frame_err  output  1  one-cycle pulse on framing error.

Function
REQ-016 Each accepted sample x for feature k SHALL be quantized to q = (x>=T[k][0]) + (x>=T[k][1]) + (x>=T[k][2]), unsigned compare, result 0..3 in 2 bits; threshold ordering not enforced.
REQ-017 FSM states: COLLECT, HOLD; reset state COLLECT.
REQ-018 In COLLECT in_ready SHALL be 1; in HOLD in_ready SHALL be 0 (combinational from state only, never from in_valid).
REQ-019 A sample is accepted when in_valid & in_ready; its code SHALL be written to slot cnt and cnt (3 bits, 0..4) incremented.
REQ-020 On acceptance with cnt==4 and in_last==1: FSM -> HOLD, out_valid=1 from next cycle, out_vec holding all five codes, cnt -> 0.
REQ-021 On acceptance with cnt==4 and in_last==0: frame_err pulse next cycle, frame discarded, cnt -> 0, stay COLLECT; subsequent samples start a new frame.
REQ-022 On acceptance with cnt<4 and in_last==1: frame_err pulse next cycle, partial frame discarded, cnt -> 0.
REQ-023 In HOLD, out_vec and out_valid SHALL stay stable until out_valid & out_ready; on that cycle FSM -> COLLECT and out_valid=0 next cycle.
REQ-024 Latency: out_valid rises exactly 1 cycle after the 5th sample's acceptance edge; back-to-back frames need one dead cycle for the handshake return (in_ready=0 during HOLD).
REQ-025 Threshold writes SHALL take effect for samples accepted from the cycle after cfg_we; a sample accepted in the same cycle as a write to its own threshold uses the old value.
REQ-026 cfg writes SHALL be accepted in any FSM state and SHALL not disturb cnt, out_vec or out_valid.
REQ-027 Slots not yet written in the current frame are don't-care internally; out_vec SHALL only change on entering HOLD.

Reset
REQ-028 On rst: state COLLECT, cnt=0, out_valid=0, out_vec=0, frame_err=0, in_ready=1 from next cycle.
REQ-029 On rst: thresholds T[k] = {64, 128, 192} for every k (FEAT_W=8; generally 1/4, 1/2, 3/4 full scale).
REQ-030 rst mid-frame or in HOLD SHALL drop any partial/pending frame without frame_err.

Verification
REQ-031 Default thresholds, samples 10,64,130,200,255 with in_last on 5th, out_ready=1 -> out_valid one cycle later, out_vec = 10'b11_11_10_01_00, cleared the following cycle.
REQ-032 Same frame, out_ready=0 for 6 cycles -> out_valid and out_vec held stable, in_ready=0 throughout, new in_valid samples ignored; release -> COLLECT.
REQ-033 in_last on 3rd sample -> frame_err single pulse, no out_valid; next 5-sample frame packs correctly.
REQ-034 5 samples without in_last -> frame_err pulse, no out_valid, cnt restarts at 0.
REQ-035 cfg write T[2][0]=200 (addr 6) in the same cycle feature c=150 is accepted -> c code 2 (old table); next frame c=150 -> code 1.
REQ-036 rst asserted while in HOLD -> out_valid=0, out_vec=0, frame_err=0 next cycle; thresholds back to 64/128/192.

Source files
------------

// File: rtl/tnn_feature_packer.sv
// Quantizes a five-sample raw feature frame into 2-bit ternary-net codes and
// holds the packed vector until the classifier side takes it.
module tnn_feature_packer #(
  parameter int FEAT_W = 8,
  parameter int N_FEAT = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [FEAT_W-1:0]   in_data,
  input  logic                in_last,
  output logic                in_ready,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_addr,
  input  logic [FEAT_W-1:0]   cfg_data,
  output logic                out_valid,
  output logic [2*N_FEAT-1:0] out_vec,
  input  logic                out_ready,
  output logic                frame_err,
  output logic                dbg_state
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam int                N_THR     = 3 * N_FEAT;
  localparam logic [2:0]        LAST_SLOT = 3'(N_FEAT - 1);
  localparam logic [FEAT_W-1:0] T_LO      = FEAT_W'(1) << (FEAT_W - 2);
  localparam logic [FEAT_W-1:0] T_MID     = FEAT_W'(1) << (FEAT_W - 1);
  localparam logic [FEAT_W-1:0] T_HI      = T_LO + T_MID;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [1:0]          codes_q [N_FEAT];
  logic [1:0]          codes_d [N_FEAT];
  logic [2*N_FEAT-1:0] out_vec_q, out_vec_d;
  logic                frame_err_q, frame_err_d;
  logic [FEAT_W-1:0]   thr_q [N_THR];
  logic [FEAT_W-1:0]   thr_d [N_THR];

  logic       accept;
  logic [3:0] base;
  logic [1:0] code;

  // Handshakes are valid/ready: a transfer happens on a rising edge where both
  // valid and ready are high; ready never depends on the matching valid.
  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign out_vec   = out_vec_q;
  assign frame_err = frame_err_q;
  assign dbg_state = state_q;
  assign accept    = in_valid & in_ready;

  // Reads the registered table, so a same-cycle cfg write is seen one sample later.
  always_comb begin
    base = {cnt_q, 1'b0} + {1'b0, cnt_q};
    code = {1'b0, (in_data >= thr_q[base])}
         + {1'b0, (in_data >= thr_q[base + 4'd1])}
         + {1'b0, (in_data >= thr_q[base + 4'd2])};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    codes_d     = codes_q;
    out_vec_d   = out_vec_q;
    frame_err_d = 1'b0;
    thr_d       = thr_q;

    if (cfg_we && cfg_addr != 4'd15) begin
      thr_d[cfg_addr] = cfg_data;
    end

    case (state_q)
      COLLECT: begin
        if (accept) begin
          codes_d[cnt_q] = code;
          if (cnt_q == LAST_SLOT && in_last) begin
            state_d = HOLD;
            cnt_d   = 3'd0;
            for (int i = 0; i < N_FEAT - 1; i++) begin
              out_vec_d[2*i +: 2] = codes_q[i];
            end
            out_vec_d[2*(N_FEAT-1) +: 2] = code;
          end else if (cnt_q == LAST_SLOT || in_last) begin
            frame_err_d = 1'b1;
            cnt_d       = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      cnt_q       <= 3'd0;
      out_vec_q   <= '0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < N_FEAT; i++) begin
        codes_q[i] <= 2'd0;
      end
      for (int i = 0; i < N_THR; i++) begin
        thr_q[i] <= (i % 3 == 0) ? T_LO : (i % 3 == 1) ? T_MID : T_HI;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_vec_q   <= out_vec_d;
      frame_err_q <= frame_err_d;
      codes_q     <= codes_d;
      thr_q       <= thr_d;
    end
  end

endmodule

// File: tb/tb_tnn_feature_packer.sv
// Directed plus randomized bench for tnn_feature_packer against a frame-level
// reference model (threshold table, sample counter, last packed vector).
module tb_tnn_feature_packer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = 4'd0;
  logic [7:0] cfg_data = 8'd0;
  logic       out_valid;
  logic [9:0] out_vec;
  logic       out_ready = 1'b0;
  logic       frame_err;
  logic       dbg_state;

  tnn_feature_packer #(.FEAT_W(8), .N_FEAT(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_vec(out_vec), .out_ready(out_ready),
    .frame_err(frame_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         thr [15];
  int         mcodes [5];
  int         mcnt;
  logic [9:0] mvec;
  int         n_vec = 0;
  int         n_err = 0;

  function automatic void model_reset();
    for (int k = 0; k < 5; k++) begin
      thr[3*k]   = 64;
      thr[3*k+1] = 128;
      thr[3*k+2] = 192;
    end
    mcnt = 0;
    mvec = '0;
  endfunction

  function automatic int quant(input int k, input int x);
    int q = 0;
    for (int l = 0; l < 3; l++) if (x >= thr[3*k+l]) q++;
    return q;
  endfunction

  function automatic logic [9:0] pack();
    logic [9:0] v = '0;
    for (int i = 0; i < 5; i++) v = v | (10'(mcodes[i]) << (2*i));
    return v;
  endfunction

  // ---------------- driver / check tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    tick();
    model_reset();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_vec", out_vec, 10'd0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] x, input logic last,
                      input logic we, input logic [3:0] a, input logic [7:0] d);
    logic exp_hold;
    logic exp_err;
    check("in_ready_collect", in_ready, 1'b1);
    in_valid = 1'b1; in_data = x; in_last = last;
    cfg_we = we; cfg_addr = a; cfg_data = d;
    mcodes[mcnt] = quant(mcnt, int'(x));
    exp_hold = 1'b0;
    exp_err  = 1'b0;
    if (mcnt == 4 && last) begin
      exp_hold = 1'b1;
      mvec = pack();
      mcnt = 0;
    end else if (mcnt == 4 || last) begin
      exp_err = 1'b1;
      mcnt = 0;
    end else begin
      mcnt++;
    end
    tick();
    if (we && a != 4'd15) thr[a] = int'(d);
    in_valid = 1'b0; in_last = 1'b0; cfg_we = 1'b0;
    check("frame_err", frame_err, exp_err);
    check("out_valid", out_valid, exp_hold);
    check("out_vec", out_vec, mvec);
    check("in_ready", in_ready, !exp_hold);
  endtask

  task automatic idle(input logic we, input logic [3:0] a, input logic [7:0] d);
    cfg_we = we; cfg_addr = a; cfg_data = d;
    tick();
    if (we && a != 4'd15) thr[a] = int'(d);
    cfg_we = 1'b0;
    check("idle_frame_err", frame_err, 1'b0);
    check("idle_out_valid", out_valid, 1'b0);
    check("idle_out_vec", out_vec, mvec);
  endtask

  // Stall for n cycles (stray samples and cfg writes must not disturb the
  // held frame), then take it.
  task automatic drain(input int n);
    logic [3:0] a;
    logic [7:0] d;
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom_range(0, 255));
      in_last = 1'($urandom_range(0, 1));
      cfg_we = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      cfg_addr = a; cfg_data = d;
      tick();
      if (cfg_we && a != 4'd15) thr[a] = int'(d);
      cfg_we = 1'b0;
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_out_vec", out_vec, mvec);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_frame_err", frame_err, 1'b0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 1'b0);
    check("release_in_ready", in_ready, 1'b1);
    check("release_out_vec", out_vec, mvec);
  endtask

  task automatic std_frame();
    send(8'd10, 1'b0, 1'b0, 4'd0, 8'd0);
    send(8'd64, 1'b0, 1'b0, 4'd0, 8'd0);
    send(8'd130, 1'b0, 1'b0, 4'd0, 8'd0);
    send(8'd200, 1'b0, 1'b0, 4'd0, 8'd0);
    send(8'd255, 1'b1, 1'b0, 4'd0, 8'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    tick();
    do_reset();

    // Default table, immediate take.
    std_frame();
    check("basic_vec_literal", out_vec, 10'b11_11_10_01_00);
    drain(0);

    // Stalled consumer for 6 cycles.
    std_frame();
    drain(6);

    // Short frame, then a good frame.
    send(8'd1, 1'b0, 1'b0, 4'd0, 8'd0);
    send(8'd2, 1'b0, 1'b0, 4'd0, 8'd0);
    send(8'd3, 1'b1, 1'b0, 4'd0, 8'd0);
    idle(1'b0, 4'd0, 8'd0);
    std_frame();
    drain(1);

    // Five samples without last, then a good frame.
    for (int i = 0; i < 5; i++) send(8'(40 * i), 1'b0, 1'b0, 4'd0, 8'd0);
    idle(1'b0, 4'd0, 8'd0);
    std_frame();
    drain(0);

    // Same-cycle threshold write uses the old table.
    send(8'd10, 1'b0, 1'b0, 4'd0, 8'd0);
    send(8'd10, 1'b0, 1'b0, 4'd0, 8'd0);
    send(8'd150, 1'b0, 1'b1, 4'd6, 8'd200);
    send(8'd10, 1'b0, 1'b0, 4'd0, 8'd0);
    send(8'd10, 1'b1, 1'b0, 4'd0, 8'd0);
    check("c_code_old_table", out_vec[5:4], 2'd2);
    drain(0);
    send(8'd10, 1'b0, 1'b0, 4'd0, 8'd0);
    send(8'd10, 1'b0, 1'b0, 4'd0, 8'd0);
    send(8'd150, 1'b0, 1'b0, 4'd0, 8'd0);
    send(8'd10, 1'b0, 1'b0, 4'd0, 8'd0);
    send(8'd10, 1'b1, 1'b0, 4'd0, 8'd0);
    check("c_code_new_table", out_vec[5:4], 2'd1);
    drain(0);

    // Reset while holding a frame restores the default table.
    for (int i = 0; i < 15; i++) idle(1'b1, 4'(i), 8'd5);
    std_frame();
    do_reset();
    std_frame();
    check("post_rst_vec_literal", out_vec, 10'b11_11_10_01_00);
    drain(0);

    // Reset mid-frame: no error, counter restarts.
    send(8'd99, 1'b0, 1'b0, 4'd0, 8'd0);
    send(8'd99, 1'b0, 1'b0, 4'd0, 8'd0);
    do_reset();
    std_frame();
    drain(0);

    // Randomized frames with random table updates.
    for (int f = 0; f < 60; f++) begin
      int len;
      logic good;
      good = ($urandom_range(0, 4) != 0);
      len = good ? 5 : int'($urandom_range(1, 5));
      for (int s = 0; s < len; s++) begin
        logic last;
        if (!good && len == 5) last = 1'b0;
        else last = (s == len - 1);
        if ($urandom_range(0, 3) == 0)
          idle(1'b1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        send(8'($urandom_range(0, 255)), last, 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      end
      if (out_valid === 1'b1) drain(int'($urandom_range(0, 3)));
      else idle(1'b0, 4'd0, 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
